// File: rtl/output_router_pkg.sv
// Shared definitions for the output router: FSM state encoding and state-class helpers.
package output_router_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // States in which words may be moved from the main FIFO into the output FIFOs.
    function automatic logic routing_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_ACTIVE);
    endfunction

    // Consumers may still drain queued data while thresholds are being reprogrammed.
    function automatic logic reading_state(input state_t s);
        return routing_state(s) || (s == ST_INIT);
    endfunction

endpackage

// File: rtl/output_router_fifo.sv
// Synchronous FIFO with occupancy count and a registered read port; callers gate
// wr_en/rd_en against full/empty.
module output_router_fifo #(
    parameter int DATA_SIZE = 6,
    parameter int ADDR_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic [ADDR_W:0]      count,
    output logic                 full,
    output logic                 empty
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_SIZE-1:0] mem_reg [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr_reg;
    logic [ADDR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [CNT_W-1:0]     count_next;
    logic [DATA_SIZE-1:0] rd_data_reg;
    logic                 rd_valid_reg;

    // Storage array kept free of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        count_next = count_reg + CNT_W'(wr_en) - CNT_W'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                rd_data_reg <= mem_reg[rd_ptr_reg];
            end
            rd_valid_reg <= rd_en;
            count_reg    <= count_next;
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign count    = count_reg;
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);

endmodule

// File: rtl/output_router.sv
// Pops words from an FWFT main FIFO and steers each into one of two output FIFOs by its
// MSB, with threshold-based back-pressure and a RESET/INIT/IDLE/ACTIVE/ERROR sequencer.
module output_router
    import output_router_pkg::*;
#(
    parameter int DATA_SIZE = 6,
    parameter int OUT_DEPTH = 4,
    parameter int ADDR_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [ADDR_W:0]      umbral_alto,
    input  logic [ADDR_W:0]      umbral_bajo,
    input  logic [DATA_SIZE-1:0] main_data,
    input  logic                 main_empty,
    output logic                 main_pop,
    input  logic                 pop0,
    input  logic                 pop1,
    output logic [DATA_SIZE-1:0] data_out0,
    output logic [DATA_SIZE-1:0] data_out1,
    output logic                 valid_out0,
    output logic                 valid_out1,
    output logic                 almost_full0,
    output logic                 almost_full1,
    output logic                 almost_empty0,
    output logic                 almost_empty1,
    output logic                 empty0,
    output logic                 empty1,
    output logic [STATE_W-1:0]   state,
    output logic                 error_out
);

    localparam int THR_W = ADDR_W + 1;

    state_t             state_reg;
    logic [THR_W-1:0]   alto_reg;
    logic [THR_W-1:0]   bajo_reg;
    logic               error_reg;

    logic [1:0]           pop_req;
    logic [1:0]           push;
    logic [1:0]           rd_en;
    logic [1:0]           full;
    logic [1:0]           empty;
    logic [1:0]           af;
    logic [1:0]           ae;
    logic [1:0]           valid;
    logic [DATA_SIZE-1:0] rdata [2];
    logic [THR_W-1:0]     count [2];

    logic d_class;
    logic route_ok;
    logic read_ok;
    logic pop_err;

    assign pop_req  = {pop1, pop0};
    assign d_class  = main_data[DATA_SIZE-1];
    assign route_ok = routing_state(state_reg);
    assign read_ok  = reading_state(state_reg);

    // A threshold above the FIFO depth can never trip almost_full, so full alone gates then.
    assign main_pop = ~main_empty & route_ok & ~af[d_class] & ~full[d_class];

    // Popping an empty FIFO is fatal even if a push lands in the same cycle.
    assign pop_err  = read_ok & (|(pop_req & empty));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_out
            localparam logic SEL = (gi == 1);

            assign push[gi]  = main_pop & (d_class == SEL);
            assign rd_en[gi] = read_ok & pop_req[gi] & ~empty[gi];

            output_router_fifo #(
                .DATA_SIZE (DATA_SIZE),
                .ADDR_W    (ADDR_W)
            ) u_fifo (
                .clk      (clk),
                .reset    (reset),
                .wr_en    (push[gi]),
                .wr_data  (main_data),
                .rd_en    (rd_en[gi]),
                .rd_data  (rdata[gi]),
                .rd_valid (valid[gi]),
                .count    (count[gi]),
                .full     (full[gi]),
                .empty    (empty[gi])
            );

            assign af[gi] = (count[gi] >= alto_reg);
            assign ae[gi] = (count[gi] <= bajo_reg);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_RESET;
            alto_reg  <= THR_W'(OUT_DEPTH);
            bajo_reg  <= '0;
            error_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_RESET: begin
                    if (init) begin
                        alto_reg <= umbral_alto;
                        bajo_reg <= umbral_bajo;
                    end
                    state_reg <= ST_INIT;
                end
                ST_INIT: begin
                    if (pop_err) begin
                        state_reg <= ST_ERROR;
                        error_reg <= 1'b1;
                    end else if (init) begin
                        alto_reg <= umbral_alto;
                        bajo_reg <= umbral_bajo;
                    end else if (bajo_reg >= alto_reg) begin
                        state_reg <= ST_ERROR;
                        error_reg <= 1'b1;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_IDLE, ST_ACTIVE: begin
                    if (pop_err) begin
                        state_reg <= ST_ERROR;
                        error_reg <= 1'b1;
                    end else if (init) begin
                        alto_reg  <= umbral_alto;
                        bajo_reg  <= umbral_bajo;
                        state_reg <= ST_INIT;
                    end else if (main_empty & (&empty)) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        state_reg <= ST_ACTIVE;
                    end
                end
                default: begin
                    state_reg <= ST_ERROR;
                    error_reg <= 1'b1;
                end
            endcase
        end
    end

    assign state         = state_reg;
    assign error_out     = error_reg;
    assign data_out0     = rdata[0];
    assign data_out1     = rdata[1];
    assign valid_out0    = valid[0];
    assign valid_out1    = valid[1];
    assign almost_full0  = af[0];
    assign almost_full1  = af[1];
    assign almost_empty0 = ae[0];
    assign almost_empty1 = ae[1];
    assign empty0        = empty[0];
    assign empty1        = empty[1];

endmodule

// File: tb/tb_output_router.sv
// Directed, table-driven bench for output_router: one record per clock cycle.
module tb_output_router;

    logic       clk;
    logic       reset;
    logic       init;
    logic [2:0] umbral_alto;
    logic [2:0] umbral_bajo;
    logic [5:0] main_data;
    logic       main_empty;
    logic       main_pop;
    logic       pop0;
    logic       pop1;
    logic [5:0] data_out0;
    logic [5:0] data_out1;
    logic       valid_out0;
    logic       valid_out1;
    logic       almost_full0;
    logic       almost_full1;
    logic       almost_empty0;
    logic       almost_empty1;
    logic       empty0;
    logic       empty1;
    logic [2:0] state;
    logic       error_out;

    output_router #(.DATA_SIZE(6), .OUT_DEPTH(4), .ADDR_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .umbral_alto   (umbral_alto),
        .umbral_bajo   (umbral_bajo),
        .main_data     (main_data),
        .main_empty    (main_empty),
        .main_pop      (main_pop),
        .pop0          (pop0),
        .pop1          (pop1),
        .data_out0     (data_out0),
        .data_out1     (data_out1),
        .valid_out0    (valid_out0),
        .valid_out1    (valid_out1),
        .almost_full0  (almost_full0),
        .almost_full1  (almost_full1),
        .almost_empty0 (almost_empty0),
        .almost_empty1 (almost_empty1),
        .empty0        (empty0),
        .empty1        (empty1),
        .state         (state),
        .error_out     (error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // x_pop is checked before the edge; everything else one step after it.
    // x_flags = {almost_full0, almost_empty0, empty0, almost_full1, almost_empty1, empty1}
    typedef struct {
        logic       rst;
        logic       ini;
        logic [2:0] alto;
        logic [2:0] bajo;
        logic [5:0] md;
        logic       me;
        logic       p0;
        logic       p1;
        logic       x_pop;
        logic [2:0] x_state;
        logic       x_v0;
        logic [5:0] x_d0;
        logic       x_v1;
        logic [5:0] x_d1;
        logic [5:0] x_flags;
        logic       x_err;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic rst, input logic ini,
                                input logic [2:0] alto, input logic [2:0] bajo,
                                input logic [5:0] md, input logic me,
                                input logic p0, input logic p1, input logic xpop,
                                input logic [2:0] xst, input logic xv0, input logic [5:0] xd0,
                                input logic xv1, input logic [5:0] xd1,
                                input logic [5:0] xfl, input logic xerr);
        vec_t v;
        v.rst = rst; v.ini = ini; v.alto = alto; v.bajo = bajo;
        v.md = md; v.me = me; v.p0 = p0; v.p1 = p1;
        v.x_pop = xpop; v.x_state = xst; v.x_v0 = xv0; v.x_d0 = xd0;
        v.x_v1 = xv1; v.x_d1 = xd1; v.x_flags = xfl; v.x_err = xerr;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        logic       got_pop;
        logic [5:0] got_flags;
        reset       = v.rst;
        init        = v.ini;
        umbral_alto = v.alto;
        umbral_bajo = v.bajo;
        main_data   = v.md;
        main_empty  = v.me;
        pop0        = v.p0;
        pop1        = v.p1;
        #1;
        got_pop = main_pop;
        @(posedge clk);
        #1;
        got_flags = {almost_full0, almost_empty0, empty0, almost_full1, almost_empty1, empty1};
        n_vec++;
        if (got_pop !== v.x_pop || state !== v.x_state || valid_out0 !== v.x_v0 ||
            data_out0 !== v.x_d0 || valid_out1 !== v.x_v1 || data_out1 !== v.x_d1 ||
            got_flags !== v.x_flags || error_out !== v.x_err) begin
            n_miss++;
            $display("FAIL vec%0d (got/required): main_pop %b/%b state %0d/%0d v0 %b/%b d0 %h/%h v1 %b/%b d1 %h/%h flags %b/%b err %b/%b",
                     idx, got_pop, v.x_pop, state, v.x_state, valid_out0, v.x_v0,
                     data_out0, v.x_d0, valid_out1, v.x_v1, data_out1, v.x_d1,
                     got_flags, v.x_flags, error_out, v.x_err);
        end else begin
            $display("vec%0d ok: state %0d main_pop %b flags %b", idx, state, got_pop, got_flags);
        end
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; umbral_alto = 3'd3; umbral_bajo = 3'd1;
        main_data = '0; main_empty = 1'b1; pop0 = 1'b0; pop1 = 1'b0;

        // Reset, one-cycle init programming alto=3/bajo=1, then IDLE.
        //            rst ini alto bajo  md    me p0 p1  pop st v0 d0     v1 d1     flags      err
        tbl.push_back(mk(1, 0, 3, 1, 6'h00, 1, 0, 0,  0, 0, 0, 6'h00, 0, 6'h00, 6'b011011, 0));
        tbl.push_back(mk(1, 0, 3, 1, 6'h00, 1, 0, 0,  0, 0, 0, 6'h00, 0, 6'h00, 6'b011011, 0));
        tbl.push_back(mk(0, 1, 3, 1, 6'h00, 1, 0, 0,  0, 1, 0, 6'h00, 0, 6'h00, 6'b011011, 0));
        tbl.push_back(mk(0, 0, 3, 1, 6'h00, 1, 0, 0,  0, 2, 0, 6'h00, 0, 6'h00, 6'b011011, 0));
        // One word of each class.
        tbl.push_back(mk(0, 0, 3, 1, 6'h05, 0, 0, 0,  1, 3, 0, 6'h00, 0, 6'h00, 6'b010011, 0));
        tbl.push_back(mk(0, 0, 3, 1, 6'h27, 0, 0, 0,  1, 3, 0, 6'h00, 0, 6'h00, 6'b010010, 0));
        // Class-0 stream stalls once count0 reaches alto=3; class 1 still flows.
        tbl.push_back(mk(0, 0, 3, 1, 6'h0A, 0, 0, 0,  1, 3, 0, 6'h00, 0, 6'h00, 6'b000010, 0));
        tbl.push_back(mk(0, 0, 3, 1, 6'h0B, 0, 0, 0,  1, 3, 0, 6'h00, 0, 6'h00, 6'b100010, 0));
        tbl.push_back(mk(0, 0, 3, 1, 6'h0C, 0, 0, 0,  0, 3, 0, 6'h00, 0, 6'h00, 6'b100010, 0));
        tbl.push_back(mk(0, 0, 3, 1, 6'h0C, 0, 0, 0,  0, 3, 0, 6'h00, 0, 6'h00, 6'b100010, 0));
        tbl.push_back(mk(0, 0, 3, 1, 6'h21, 0, 0, 0,  1, 3, 0, 6'h00, 0, 6'h00, 6'b100000, 0));
        // Reads: head 05, then push+pop same cycle (count stays 2), then hold, then out1.
        tbl.push_back(mk(0, 0, 3, 1, 6'h00, 1, 1, 0,  0, 3, 1, 6'h05, 0, 6'h00, 6'b000000, 0));
        tbl.push_back(mk(0, 0, 3, 1, 6'h0C, 0, 1, 0,  1, 3, 1, 6'h0A, 0, 6'h00, 6'b000000, 0));
        tbl.push_back(mk(0, 0, 3, 1, 6'h00, 1, 0, 0,  0, 3, 0, 6'h0A, 0, 6'h00, 6'b000000, 0));
        tbl.push_back(mk(0, 0, 3, 1, 6'h00, 1, 0, 1,  0, 3, 0, 6'h0A, 1, 6'h27, 6'b000010, 0));

        foreach (tbl[i]) apply(tbl[i], i);

        // Drain out1, then pop it while empty: ERROR, and everything freezes.
        apply(mk(0, 0, 3, 1, 6'h00, 1, 0, 1,  0, 3, 0, 6'h0A, 1, 6'h21, 6'b000011, 0), 100);
        apply(mk(0, 0, 3, 1, 6'h00, 1, 0, 1,  0, 4, 0, 6'h0A, 0, 6'h21, 6'b000011, 1), 101);
        apply(mk(0, 0, 3, 1, 6'h0D, 0, 1, 0,  0, 4, 0, 6'h0A, 0, 6'h21, 6'b000011, 1), 102);
        apply(mk(0, 0, 3, 1, 6'h0D, 0, 0, 1,  0, 4, 0, 6'h0A, 0, 6'h21, 6'b000011, 1), 103);

        // Reset with two words still in out0 discards them and restores default thresholds.
        apply(mk(1, 0, 3, 1, 6'h00, 1, 0, 0,  0, 0, 0, 6'h00, 0, 6'h00, 6'b011011, 0), 200);
        apply(mk(0, 0, 3, 1, 6'h00, 1, 0, 0,  0, 1, 0, 6'h00, 0, 6'h00, 6'b011011, 0), 201);
        apply(mk(0, 0, 3, 1, 6'h00, 1, 0, 0,  0, 2, 0, 6'h00, 0, 6'h00, 6'b011011, 0), 202);
        // Reprogramming with bajo == alto is rejected at INIT exit.
        apply(mk(0, 1, 2, 2, 6'h00, 1, 0, 0,  0, 1, 0, 6'h00, 0, 6'h00, 6'b011011, 0), 203);
        apply(mk(0, 0, 2, 2, 6'h00, 1, 0, 0,  0, 4, 0, 6'h00, 0, 6'h00, 6'b011011, 1), 204);

        // alto=7 exceeds depth 4: only the full flag stops class-1 pushes.
        apply(mk(1, 0, 7, 0, 6'h00, 1, 0, 0,  0, 0, 0, 6'h00, 0, 6'h00, 6'b011011, 0), 300);
        apply(mk(0, 1, 7, 0, 6'h00, 1, 0, 0,  0, 1, 0, 6'h00, 0, 6'h00, 6'b011011, 0), 301);
        apply(mk(0, 0, 7, 0, 6'h00, 1, 0, 0,  0, 2, 0, 6'h00, 0, 6'h00, 6'b011011, 0), 302);
        for (int k = 0; k < 4; k++) begin
            apply(mk(0, 0, 7, 0, 6'h30, 0, 0, 0,  1, 3, 0, 6'h00, 0, 6'h00, 6'b011000, 0), 303 + k);
        end
        apply(mk(0, 0, 7, 0, 6'h30, 0, 0, 0,  0, 3, 0, 6'h00, 0, 6'h00, 6'b011000, 0), 307);
        // Read the first full-gated word back to confirm the class bit is stored.
        apply(mk(0, 0, 7, 0, 6'h00, 1, 0, 1,  0, 3, 0, 6'h00, 1, 6'h30, 6'b011000, 0), 308);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
